// File: rtl/btree_switch_rr.sv
// Three-port binary-tree NoC switch node: per-input show-ahead FIFOs, packet-locked
// round-robin arbitration per output, registered outputs, U-turn packet dropping.
module btree_switch_rr #(
    parameter int DATA_WIDTH = 36,
    parameter int ADDR_WIDTH = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int LEFT_MIN   = 0,
    parameter int LEFT_MAX   = 0,
    parameter int RIGHT_MIN  = 1,
    parameter int RIGHT_MAX  = 1,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                    i_clk,
    input  logic                    i_reset_n,
    input  logic [3*DATA_WIDTH-1:0] i_data,
    input  logic [2:0]              i_valid,
    input  logic [2:0]              i_last,
    output logic [2:0]              o_ready,
    output logic [3*DATA_WIDTH-1:0] o_data,
    output logic [2:0]              o_valid,
    output logic [2:0]              o_last,
    input  logic [2:0]              i_ready,
    output logic [CNT_WIDTH-1:0]    o_drop_cnt
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int EW = DATA_WIDTH + 1;

    function automatic logic [1:0] route_f(input logic [ADDR_WIDTH-1:0] addr);
        int a;
        a = int'(addr);
        if (a >= LEFT_MIN && a <= LEFT_MAX) begin
            return 2'd0;
        end else if (a >= RIGHT_MIN && a <= RIGHT_MAX) begin
            return 2'd1;
        end else begin
            return 2'd2;
        end
    endfunction

    // sel = 0 picks the lower-index eligible input of output o, sel = 1 the higher one
    function automatic logic [1:0] elig_f(input logic [1:0] o, input logic sel);
        case (o)
            2'd0:    return sel ? 2'd2 : 2'd1;
            2'd1:    return sel ? 2'd2 : 2'd0;
            default: return sel ? 2'd1 : 2'd0;
        endcase
    endfunction

    logic [EW-1:0]           mem_q [3][FIFO_DEPTH];
    logic [PW-1:0]           rd_q [3];
    logic [PW-1:0]           wr_q [3];
    logic [PW:0]             cnt_q [3];
    logic [1:0]              rt_q [3];
    logic [2:0]              rdy_q, head_q, lock_q, lsrc_q, rr_q;
    logic [3*DATA_WIDTH-1:0] odata_q;
    logic [2:0]              oval_q, olast_q;
    logic [CNT_WIDTH-1:0]    dcnt_q;

    logic [EW-1:0]           hd_s [3];
    logic [EW-1:0]           ld_s [3];
    logic [1:0]              rt_s [3];
    logic [1:0]              gsrc_s [3];
    logic [PW:0]             cnt_d [3];
    logic [2:0]              push_s, pop_s, nempty_s, drop_s, load_s, gsel_s;
    logic [1:0]              ia_s, ib_s, ndrop_s;
    logic                    ra_s, rb_s, ok_s;
    logic [CNT_WIDTH+1:0]    dsum_s;
    logic [CNT_WIDTH-1:0]    dcnt_d;

    // Routing, arbitration, FIFO pop/push decisions and drop counter next value
    always_comb begin
        ia_s    = 2'd0;
        ib_s    = 2'd0;
        ra_s    = 1'b0;
        rb_s    = 1'b0;
        ok_s    = 1'b0;
        ndrop_s = 2'd0;
        pop_s   = 3'b000;
        load_s  = 3'b000;
        gsel_s  = 3'b000;
        for (int k = 0; k < 3; k++) begin
            hd_s[k]     = mem_q[k][rd_q[k]];
            nempty_s[k] = (cnt_q[k] != '0);
            push_s[k]   = i_valid[k] & rdy_q[k];
            if (head_q[k]) begin
                rt_s[k] = route_f(hd_s[k][DATA_WIDTH-1 -: ADDR_WIDTH]);
            end else begin
                rt_s[k] = rt_q[k];
            end
            drop_s[k] = nempty_s[k] && (rt_s[k] == 2'(k));
        end
        for (int o = 0; o < 3; o++) begin
            ia_s = elig_f(2'(o), 1'b0);
            ib_s = elig_f(2'(o), 1'b1);
            ra_s = nempty_s[ia_s] && (rt_s[ia_s] == 2'(o));
            rb_s = nempty_s[ib_s] && (rt_s[ib_s] == 2'(o));
            ok_s = !oval_q[o] || i_ready[o];
            // A locked output only serves its owner, even when the owner's FIFO is empty
            if (lock_q[o]) begin
                gsel_s[o] = lsrc_q[o];
                load_s[o] = ok_s && (lsrc_q[o] ? rb_s : ra_s);
            end else if (ra_s && rb_s) begin
                gsel_s[o] = rr_q[o];
                load_s[o] = ok_s;
            end else begin
                gsel_s[o] = rb_s;
                load_s[o] = ok_s && (ra_s || rb_s);
            end
            gsrc_s[o] = elig_f(2'(o), gsel_s[o]);
            ld_s[o]   = hd_s[gsrc_s[o]];
        end
        for (int k = 0; k < 3; k++) begin
            pop_s[k] = drop_s[k]
                     | (load_s[0] && (gsrc_s[0] == 2'(k)))
                     | (load_s[1] && (gsrc_s[1] == 2'(k)))
                     | (load_s[2] && (gsrc_s[2] == 2'(k)));
            cnt_d[k] = cnt_q[k] + (PW+1)'(push_s[k]) - (PW+1)'(pop_s[k]);
            ndrop_s  = ndrop_s + 2'(drop_s[k] & head_q[k]);
        end
        dsum_s = {2'b00, dcnt_q} + (CNT_WIDTH+2)'(ndrop_s);
        if (dsum_s > {2'b00, {CNT_WIDTH{1'b1}}}) begin
            dcnt_d = {CNT_WIDTH{1'b1}};
        end else begin
            dcnt_d = dsum_s[CNT_WIDTH-1:0];
        end
    end

    // FIFO storage write port (contents need no reset; occupancy is tracked by cnt_q)
    always_ff @(posedge i_clk) begin
        for (int k = 0; k < 3; k++) begin
            if (push_s[k]) begin
                mem_q[k][wr_q[k]] <= {i_last[k], i_data[k*DATA_WIDTH +: DATA_WIDTH]};
            end
        end
    end

    // FIFO pointers, packet tracking, locks, round-robin pointers, output registers
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int k = 0; k < 3; k++) begin
                rd_q[k]  <= '0;
                wr_q[k]  <= '0;
                cnt_q[k] <= '0;
                rt_q[k]  <= 2'd0;
            end
            rdy_q   <= 3'b000;
            head_q  <= 3'b111;
            lock_q  <= 3'b000;
            lsrc_q  <= 3'b000;
            rr_q    <= 3'b000;
            odata_q <= '0;
            oval_q  <= 3'b000;
            olast_q <= 3'b000;
            dcnt_q  <= '0;
        end else begin
            for (int k = 0; k < 3; k++) begin
                wr_q[k]  <= wr_q[k] + PW'(push_s[k]);
                rd_q[k]  <= rd_q[k] + PW'(pop_s[k]);
                cnt_q[k] <= cnt_d[k];
                rdy_q[k] <= (cnt_d[k] != (PW+1)'(FIFO_DEPTH));
                if (pop_s[k]) begin
                    head_q[k] <= hd_s[k][DATA_WIDTH];
                    if (head_q[k]) begin
                        rt_q[k] <= rt_s[k];
                    end
                end
            end
            for (int o = 0; o < 3; o++) begin
                if (load_s[o]) begin
                    odata_q[o*DATA_WIDTH +: DATA_WIDTH] <= ld_s[o][DATA_WIDTH-1:0];
                    olast_q[o] <= ld_s[o][DATA_WIDTH];
                    oval_q[o]  <= 1'b1;
                    if (ld_s[o][DATA_WIDTH]) begin
                        lock_q[o] <= 1'b0;
                        rr_q[o]   <= ~gsel_s[o];
                    end else begin
                        lock_q[o] <= 1'b1;
                        lsrc_q[o] <= gsel_s[o];
                    end
                end else if (i_ready[o]) begin
                    oval_q[o] <= 1'b0;
                end
            end
            dcnt_q <= dcnt_d;
        end
    end

    assign o_ready    = rdy_q;
    assign o_data     = odata_q;
    assign o_valid    = oval_q;
    assign o_last     = olast_q;
    assign o_drop_cnt = dcnt_q;

endmodule

// File: tb/tb_btree_switch_rr.sv
// Directed bench for btree_switch_rr: routing vector table plus sequences for
// packet locking, round-robin, U-turn drop, backpressure, mid-packet reset, counter saturation.
module tb_btree_switch_rr;

    localparam int DW = 36;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [3*DW-1:0] i_data;
    logic [2:0]      i_valid, i_last, i_ready;
    logic [2:0]      o_ready, o_valid, o_last;
    logic [3*DW-1:0] o_data;
    logic [15:0]     o_drop_cnt;

    logic [3*DW-1:0] d2_data;
    logic [2:0]      d2_valid;
    logic [2:0]      d2_last = 3'b111;
    logic [2:0]      d2_iready = 3'b111;
    logic [2:0]      d2_ready, d2_ovalid, d2_olast;
    logic [3*DW-1:0] d2_odata;
    logic [1:0]      d2_cnt;

    int n_cmp = 0;
    int n_err = 0;
    int exp_drops = 0;

    always #5 clk = ~clk;

    btree_switch_rr dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_data(i_data), .i_valid(i_valid), .i_last(i_last),
        .o_ready(o_ready), .o_data(o_data), .o_valid(o_valid), .o_last(o_last),
        .i_ready(i_ready), .o_drop_cnt(o_drop_cnt)
    );

    btree_switch_rr #(.CNT_WIDTH(2)) dut2 (
        .i_clk(clk), .i_reset_n(rst_n), .i_data(d2_data), .i_valid(d2_valid), .i_last(d2_last),
        .o_ready(d2_ready), .o_data(d2_odata), .o_valid(d2_ovalid), .o_last(d2_olast),
        .i_ready(d2_iready), .o_drop_cnt(d2_cnt)
    );

    typedef struct {
        int         src;
        logic [3:0] addr;
        int         dst;   // 3 means the packet must be dropped
    } vec_t;

    function automatic logic [DW-1:0] mk(input logic [3:0] a, input logic [31:0] p);
        return {a, p};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One single-flit packet, checked exactly two edges after it is offered
    task automatic send1(input int src, input logic [3:0] addr, input int dst, input logic [31:0] pay);
        logic [DW-1:0] f;
        f = mk(addr, pay);
        i_data = '0;
        i_data[src*DW +: DW] = f;
        i_valid = 3'b000;
        i_valid[src] = 1'b1;
        i_last = 3'b111;
        tick();
        i_valid = 3'b000;
        tick();
        for (int o = 0; o < 3; o++) begin
            chk($sformatf("route src%0d addr%0d valid%0d", src, addr, o), o_valid[o], (o == dst));
        end
        if (dst < 3) begin
            chk($sformatf("route src%0d addr%0d data", src, addr), o_data[dst*DW +: DW], f);
            chk($sformatf("route src%0d addr%0d last", src, addr), o_last[dst], 1'b1);
        end else begin
            exp_drops++;
        end
        chk($sformatf("drop count after src%0d addr%0d", src, addr), o_drop_cnt, exp_drops);
        tick();
        chk("valid clears after consume", o_valid, 3'b000);
    endtask

    initial begin
        vec_t          vecs[9];
        logic [DW-1:0] expq[6];
        logic [2:0]    expl[6];
        logic [2:0]    anyv;
        int            got, acc;

        vecs[0] = '{0, 4'd1, 1};
        vecs[1] = '{0, 4'd5, 2};
        vecs[2] = '{1, 4'd0, 0};
        vecs[3] = '{1, 4'd9, 2};
        vecs[4] = '{2, 4'd0, 0};
        vecs[5] = '{2, 4'd1, 1};
        vecs[6] = '{2, 4'd15, 3};
        vecs[7] = '{0, 4'd0, 3};
        vecs[8] = '{1, 4'd1, 3};

        i_data = '0; i_valid = 3'b000; i_last = 3'b000; i_ready = 3'b111;
        d2_data = '0; d2_valid = 3'b000;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        tick();
        tick();
        chk("reset o_ready", o_ready, 3'b000);
        chk("reset o_valid", o_valid, 3'b000);
        chk("reset o_last", o_last, 3'b000);
        chk("reset o_data", o_data, '0);
        chk("reset drop cnt", o_drop_cnt, 16'd0);
        rst_n = 1'b1;
        tick();
        chk("ready after release", o_ready, 3'b111);

        for (int i = 0; i < 9; i++) begin
            send1(vecs[i].src, vecs[i].addr, vecs[i].dst, 32'h1000_0000 + 32'(i));
        end

        // Two 3-flit packets contend for the parent port: no interleave, port0 first
        for (int j = 0; j < 3; j++) begin
            expq[j]   = mk(4'd5, 32'hA000_0000 + 32'(j));
            expq[j+3] = mk(4'd5, 32'hB000_0000 + 32'(j));
            expl[j]   = (j == 2) ? 3'b001 : 3'b000;
            expl[j+3] = expl[j];
        end
        got = 0;
        for (int c = 0; c < 40; c++) begin
            if (o_valid[2]) begin
                if (got < 6) begin
                    chk($sformatf("pkt order flit %0d", got), o_data[2*DW +: DW], expq[got]);
                    chk($sformatf("pkt order last %0d", got), o_last[2], expl[got][0]);
                end
                got++;
            end
            if (c < 3) begin
                i_data = '0;
                i_data[0*DW +: DW] = expq[c];
                i_data[1*DW +: DW] = expq[c+3];
                i_valid = 3'b011;
                i_last = (c == 2) ? 3'b011 : 3'b000;
            end else begin
                i_valid = 3'b000;
            end
            tick();
        end
        chk("pkt order flit count", got, 6);

        // Port0 alone finishes a packet, so the following contention goes to port1
        send1(0, 4'd5, 2, 32'hC000_0000);
        i_data = '0;
        i_data[0*DW +: DW] = mk(4'd6, 32'hD000_0000);
        i_data[1*DW +: DW] = mk(4'd6, 32'hD000_0001);
        i_valid = 3'b011;
        i_last = 3'b111;
        tick();
        i_valid = 3'b000;
        tick();
        chk("rr first winner", o_data[2*DW +: DW], mk(4'd6, 32'hD000_0001));
        tick();
        chk("rr second winner", o_data[2*DW +: DW], mk(4'd6, 32'hD000_0000));
        tick();

        // Two-flit U-turn from port0; body carries a different address but must follow the head
        i_data = '0;
        i_data[0*DW +: DW] = mk(4'd0, 32'hE000_0000);
        i_valid = 3'b001;
        i_last = 3'b000;
        tick();
        i_data[0*DW +: DW] = mk(4'd1, 32'hE000_0001);
        i_last = 3'b001;
        tick();
        i_valid = 3'b000;
        anyv = 3'b000;
        for (int c = 0; c < 6; c++) begin
            anyv = anyv | o_valid;
            tick();
        end
        chk("uturn no output", anyv, 3'b000);
        exp_drops++;
        chk("uturn drop count", o_drop_cnt, exp_drops);
        send1(0, 4'd1, 1, 32'hE000_0002);

        // Backpressure on parent output: 1 in register + 4 in FIFO, then drain in order
        i_ready = 3'b011;
        acc = 0;
        for (int c = 0; c < 12; c++) begin
            if (o_ready[0]) begin
                i_data = '0;
                i_data[0*DW +: DW] = mk(4'd7, 32'hF000_0000 + 32'(acc));
                i_valid = 3'b001;
                i_last = 3'b111;
                tick();
                acc++;
            end else begin
                i_valid = 3'b000;
                tick();
            end
        end
        i_valid = 3'b000;
        chk("stall accepts", acc, 5);
        chk("stall o_ready", o_ready[0], 1'b0);
        chk("stall held valid", o_valid[2], 1'b1);
        chk("stall held data", o_data[2*DW +: DW], mk(4'd7, 32'hF000_0000));
        i_ready = 3'b111;
        got = 0;
        for (int c = 0; c < 20; c++) begin
            if (o_valid[2]) begin
                chk($sformatf("drain flit %0d", got), o_data[2*DW +: DW], mk(4'd7, 32'hF000_0000 + 32'(got)));
                got++;
            end
            tick();
        end
        chk("drain count", got, 5);
        chk("ready after drain", o_ready, 3'b111);

        // Reset in the middle of a port1 -> parent packet
        i_data = '0;
        i_data[1*DW +: DW] = mk(4'd9, 32'h5000_0000);
        i_valid = 3'b010;
        i_last = 3'b000;
        tick();
        i_data[1*DW +: DW] = mk(4'd9, 32'h5000_0001);
        tick();
        chk("pre-reset head out", o_valid[2], 1'b1);
        i_data[1*DW +: DW] = mk(4'd9, 32'h5000_0002);
        #2 rst_n = 1'b0;
        #1;
        chk("mid-pkt reset o_valid", o_valid, 3'b000);
        chk("mid-pkt reset o_ready", o_ready, 3'b000);
        i_valid = 3'b000;
        tick();
        tick();
        rst_n = 1'b1;
        exp_drops = 0;
        tick();
        chk("post-reset ready", o_ready, 3'b111);
        chk("post-reset drop cnt", o_drop_cnt, 16'd0);
        i_data = '0;
        i_data[0*DW +: DW] = mk(4'd9, 32'h6000_0000);
        i_valid = 3'b001;
        i_last = 3'b000;
        tick();
        i_data[0*DW +: DW] = mk(4'd9, 32'h6000_0001);
        i_last = 3'b001;
        tick();
        i_valid = 3'b000;
        chk("post-reset head granted", o_valid[2], 1'b1);
        chk("post-reset head data", o_data[2*DW +: DW], mk(4'd9, 32'h6000_0000));
        tick();
        chk("post-reset body data", o_data[2*DW +: DW], mk(4'd9, 32'h6000_0001));
        chk("post-reset body last", o_last[2], 1'b1);
        tick();

        // Narrow counter saturates
        for (int i = 0; i < 5; i++) begin
            d2_data = '0;
            d2_data[2*DW +: DW] = mk(4'd15, 32'(i));
            d2_valid = 3'b100;
            tick();
            d2_valid = 3'b000;
            tick();
            chk($sformatf("sat count %0d", i), d2_cnt, (i + 1 > 3) ? 3 : i + 1);
        end
        chk("sat dut no output", d2_ovalid, 3'b000);
        chk("sat dut no last", d2_olast, 3'b000);
        chk("sat dut data", d2_odata, '0);
        chk("sat dut ready", d2_ready, 3'b111);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
